// File: rtl/jtframe_6809_romfetch_if.sv
// SDRAM slot handshake between the 6809 ROM fetch bridge and the arbiter.
// The master modport is the fetch bridge. The slave modport is the arbiter slot.
interface jtframe_6809_romfetch_if #(
  parameter int AW = 16
);
  logic [AW-3:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   din;

  modport master (
    output sdram_addr,
    output sdram_req,
    input  sdram_ack,
    input  data_rdy,
    input  din
  );

  modport slave (
    input  sdram_addr,
    input  sdram_req,
    output sdram_ack,
    output data_rdy,
    output din
  );
endinterface

// File: rtl/jtframe_6809_romfetch.sv
// ROM fetch bridge for the 6809: turns CPU byte reads into 32-bit SDRAM word
// requests, backed by a 2-line x 4-byte cache with a single toggling victim.
module jtframe_6809_romfetch #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int SW = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AW-1:0]                 addr,
  input  logic                          addr_ok,
  input  logic                          flush,
  output logic [DW-1:0]                 dout,
  output logic                          data_ok,
  jtframe_6809_romfetch_if.master       sdram
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state;
  logic [AW-3:0] tag [2];
  logic [SW-1:0] data [2];
  logic [1:0]    valid;
  logic          victim;
  logic [AW-3:0] req_tag;
  logic          req;
  logic          flushed;   // a flush landed while the current fetch was in flight

  logic [AW-3:0] addr_tag;
  logic [1:0]    hit;
  logic          fill;
  logic [SW-1:0] line;

  assign addr_tag = addr[AW-1:2];
  assign hit[0]   = valid[0] && (tag[0] == addr_tag);
  assign hit[1]   = valid[1] && (tag[1] == addr_tag);
  assign data_ok  = addr_ok && (hit != 2'b00) && !flush;

  // data_rdy together with the ack skips WAIT and fills straight away
  assign fill = ((state == REQ) && sdram.sdram_ack && sdram.data_rdy) ||
                ((state == WAIT) && sdram.data_rdy);

  assign sdram.sdram_addr = req_tag;
  assign sdram.sdram_req  = req;

  // Byte select from the hitting line, line 0 taking priority
  always_comb begin
    line = hit[0] ? data[0] : data[1];
    dout = line[{addr[1:0], 3'b000} +: DW];
  end

  // Line data storage, no reset needed since valid bits gate its use
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      data[victim] <= sdram.din;
    end
  end

  // Fetch FSM, tags, valid bits and victim pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      victim  <= 1'b0;
      req_tag <= '0;
      req     <= 1'b0;
      flushed <= 1'b0;
    end else begin
      if (fill) begin
        tag[victim]   <= req_tag;
        valid[victim] <= !(flush || flushed);
        victim        <= !victim;
      end
      // Whole-vector clear placed last so flush beats a same-cycle fill
      if (flush) begin
        valid <= '0;
      end
      case (state)
        IDLE: begin
          if (addr_ok && (hit == 2'b00) && !flush) begin
            req_tag <= addr_tag;
            req     <= 1'b1;
            flushed <= 1'b0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            flushed <= 1'b1;
          end
          if (sdram.sdram_ack) begin
            req   <= 1'b0;
            state <= sdram.data_rdy ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            flushed <= 1'b1;
          end
          if (sdram.data_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
